// File: rtl/muldiv_seq.sv
// Iterative RISC-V M-extension unit: radix-2^MUL_STEP multiplier, radix-2 restoring divider
// and an optional cache of the last division's unsigned quotient/remainder.
module muldiv_seq #(
    parameter int XLEN      = 32,
    parameter int MUL_STEP  = 4,
    parameter int REM_CACHE = 1
) (
    input  logic            clk,
    input  logic            rstHigh,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] c_o,
    output logic            busy_o,
    output logic            done_o
);
    localparam int ACC_W = 2*XLEN + MUL_STEP;
    localparam int CNT_W = 7;
    localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[31]) ? (x | HI_MASK) : (x & ~HI_MASK);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    state_t state, state_nxt;

    logic            in_div, in_word, in_sa, in_sb, neg_a, neg_b;
    logic            div_zero, div_ovf, in_special, cache_hit, accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg, rs1_w, spec_val;
    int              in_w, iter;

    logic [2:0]        op;
    logic              op_word, neg_q, neg_r, is_special;
    logic [XLEN-1:0]   special_val, cap_a, cap_b;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] mcand, prod;
    logic [XLEN-1:0]   mplier, quo, fix_val;
    logic [ACC_W-1:0]  acc, partial;
    logic [XLEN:0]     rem_part, div_shift;
    logic              div_ge;

    logic            cache_vld, cache_word;
    logic [XLEN-1:0] cache_a, cache_b, cache_q, cache_r;
    logic            unused_bits;

    // Operand decode at acceptance: extension, magnitudes, special cases, cache lookup
    always_comb begin
        in_div  = funct3_i[2];
        in_word = (XLEN == 64) && word_i && (funct3_i == 3'b000 || in_div);
        in_sa   = in_div ? !funct3_i[0] : (funct3_i != 3'b011);
        in_sb   = in_div ? !funct3_i[0] : !funct3_i[1];
        a_ext   = in_word ? word_ext(rs1_i, in_sa) : rs1_i;
        b_ext   = in_word ? word_ext(rs2_i, in_sb) : rs2_i;
        neg_a   = in_sa && a_ext[XLEN-1];
        neg_b   = in_sb && b_ext[XLEN-1];
        mag_a   = cond_neg(a_ext, neg_a);
        mag_b   = cond_neg(b_ext, neg_b);
        min_neg = in_word ? (HI_MASK | XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero   = in_div && (b_ext == '0);
        div_ovf    = in_div && !funct3_i[0] && (a_ext == min_neg) && (&b_ext);
        in_special = div_zero || div_ovf;
        rs1_w      = in_word ? word_ext(rs1_i, 1'b1) : rs1_i;
        if (funct3_i[1]) spec_val = div_zero ? rs1_w : '0;
        else             spec_val = div_zero ? '1 : rs1_w;
        cache_hit = (REM_CACHE != 0) && cache_vld && in_div && !in_special &&
                    (mag_a == cache_a) && (mag_b == cache_b) && (in_word == cache_word);
        in_w = in_word ? 32 : XLEN;
        iter = in_div ? in_w : in_w / MUL_STEP;
    end

    assign accept = (state == IDLE) && start_i && !kill_i && !rstHigh;
    assign busy_o = !rstHigh && ((state != IDLE) || (start_i && !kill_i));

    always_ff @(posedge clk) begin
        if (rstHigh) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i && !kill_i) state_nxt = (in_special || cache_hit) ? FIX : CALC;
            CALC: if (kill_i) state_nxt = IDLE;
                  else if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration of each engine
    always_comb begin
        partial   = ACC_W'(mcand) * ACC_W'(mplier[MUL_STEP-1:0]);
        div_shift = {rem_part[XLEN-1:0], quo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, cap_b};
    end

    // Capture stage / iteration stage
    always_ff @(posedge clk) begin
        if (accept) begin
            op          <= funct3_i;
            op_word     <= in_word;
            neg_q       <= neg_a ^ neg_b;
            neg_r       <= neg_a;
            is_special  <= in_special;
            special_val <= spec_val;
            cap_a       <= mag_a;
            cap_b       <= mag_b;
            cnt         <= CNT_W'(iter - 1);
            mcand       <= (2*XLEN)'(mag_a);
            mplier      <= mag_b;
            acc         <= '0;
            quo         <= cache_hit ? cache_q : (mag_a << (XLEN - in_w));
            rem_part    <= cache_hit ? {1'b0, cache_r} : '0;
        end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            if (!op[2]) begin
                acc    <= acc + partial;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
            end else begin
                rem_part <= div_ge ? (div_shift - {1'b0, cap_b}) : div_shift;
                quo      <= {quo[XLEN-2:0], div_ge};
            end
        end
    end

    // Sign fix and result selection
    always_comb begin
        prod = acc[2*XLEN-1:0];
        if (neg_q) prod = -prod;
        fix_val = '0;
        case (op)
            3'b000:                 fix_val = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = cond_neg(quo, neg_q);
            default:                fix_val = cond_neg(rem_part[XLEN-1:0], neg_r);
        endcase
        if (op_word)    fix_val = word_ext(fix_val, 1'b1);
        if (is_special) fix_val = special_val;
    end

    // FIX stage: result register, done pulse and cache maintenance
    always_ff @(posedge clk) begin
        if (rstHigh) begin
            c_o       <= '0;
            done_o    <= 1'b0;
            cache_vld <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state == FIX && !kill_i) begin
                c_o    <= fix_val;
                done_o <= 1'b1;
            end
            if (kill_i && (state != IDLE || start_i)) begin
                cache_vld <= 1'b0;
            end else if (REM_CACHE != 0 && state == FIX && op[2] && !is_special) begin
                cache_vld  <= 1'b1;
                cache_a    <= cap_a;
                cache_b    <= cap_b;
                cache_word <= op_word;
                cache_q    <= quo;
                cache_r    <= rem_part[XLEN-1:0];
            end
        end
    end

    // Accumulator headroom and the remainder guard bit never reach the result
    assign unused_bits = ^{acc[ACC_W-1:2*XLEN], rem_part[XLEN]};

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed and random ops on XLEN=32 and XLEN=64 instances, checked
// against an arithmetic reference model that also tracks latency and the division cache.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, start, word, kill, sel64;
    logic [2:0]  f3;
    logic [63:0] rs1, rs2;
    logic [31:0] c32;
    logic [63:0] c64, c;
    logic        busy32, busy64, done32, done64, busy, done;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32), .MUL_STEP(4), .REM_CACHE(1)) d32 (
        .clk(clk), .rstHigh(rst), .start_i(start & !sel64), .funct3_i(f3), .word_i(word),
        .rs1_i(rs1[31:0]), .rs2_i(rs2[31:0]), .kill_i(kill & !sel64),
        .c_o(c32), .busy_o(busy32), .done_o(done32));

    muldiv_seq #(.XLEN(64), .MUL_STEP(4), .REM_CACHE(1)) d64 (
        .clk(clk), .rstHigh(rst), .start_i(start & sel64), .funct3_i(f3), .word_i(word),
        .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill & sel64),
        .c_o(c64), .busy_o(busy64), .done_o(done64));

    assign c    = sel64 ? c64 : {32'b0, c32};
    assign busy = sel64 ? busy64 : busy32;
    assign done = sel64 ? done64 : done32;

    int checks = 0;
    int failures = 0;

    bit          cvalid[2];
    bit          cw[2];
    logic [63:0] ca[2], cb[2], last_c[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [129:0] opnd(input logic [63:0] v, input int w, input bit sgn);
        logic signed [129:0] r;
        if (w == 32) r = {{98{sgn & v[31]}}, v[31:0]};
        else         r = {{66{sgn & v[63]}}, v};
        return r;
    endfunction

    task automatic model(input bit s64, input logic [2:0] f, input bit w,
                         input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] val, output int cyc, output bit cacheable,
                         output logic [63:0] ma, output logic [63:0] mb, output bit ew);
        int W;
        bit sa, sb, special, hit;
        logic signed [129:0] A, B, p, q, r, res;
        logic [63:0] mask;
        ew = s64 && w && (f == 3'b000 || f[2]);
        W  = ew ? 32 : (s64 ? 64 : 32);
        sa = f[2] ? !f[0] : (f != 3'b011);
        sb = f[2] ? !f[0] : !f[1];
        A  = opnd(a, W, sa);
        B  = opnd(b, W, sb);
        ma = 64'((A < 0) ? -A : A);
        mb = 64'((B < 0) ? -B : B);
        mask = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        special = 0; hit = 0; cacheable = 0;
        if (!f[2]) begin
            p   = A * B;
            res = (f == 3'b000) ? p : (p >>> W);
            cyc = W / 4 + 2;
        end else begin
            if (B == 0) begin
                q = -1; r = A; special = 1;
            end else begin
                q = A / B; r = A % B;
                special = sa && (q == (130'sd1 <<< (W - 1)));
            end
            hit = !special && cvalid[s64] && ca[s64] == ma && cb[s64] == mb && cw[s64] == ew;
            cyc = (special || hit) ? 2 : W + 2;
            cacheable = !special;
            res = f[1] ? r : q;
        end
        val = 64'(res) & mask;
        if (ew) val = {{32{val[31]}}, val[31:0]};
    endtask

    // abort_at: cycle in which kill (or reset when abort_rst) is held; poke_at: cycle of an ignored start
    task automatic run_op(input string tag, input bit s64, input logic [2:0] f, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int abort_at, input bit abort_rst, input int poke_at);
        logic [63:0] val, ma, mb;
        int cyc, n, limit;
        bit cacheable, ew, got;
        model(s64, f, w, a, b, val, cyc, cacheable, ma, mb, ew);
        sel64 = s64; f3 = f; word = w; rs1 = a; rs2 = b; start = 1'b1;
        #1;
        check({tag, ":busy0"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; got = 0;
        limit = (abort_at > 0) ? abort_at : 100;
        while (!got && n <= limit) begin
            if (done) got = 1;
            else begin
                if (n == abort_at) begin
                    if (abort_rst) rst = 1'b1;
                    else           kill = 1'b1;
                end
                if (n == poke_at) begin
                    start = 1'b1; rs1 = ~a; f3 = ~f;
                end
                @(posedge clk); #1;
                kill = 1'b0; rst = 1'b0; start = 1'b0;
                n++;
            end
        end
        if (abort_at > 0) begin
            check({tag, ":no_done"}, 64'(got || done), 64'd0);
            check({tag, ":busy_after"}, 64'(busy), 64'd0);
            if (abort_rst) begin
                last_c[0] = '0; last_c[1] = '0;
                cvalid[0] = 0; cvalid[1] = 0;
            end else begin
                cvalid[s64] = 0;
            end
            check({tag, ":c_held"}, c, last_c[s64]);
        end else begin
            check({tag, ":latency"}, got ? 64'(n) : '1, 64'(cyc));
            check({tag, ":value"}, c, val);
            check({tag, ":busy_done"}, 64'(busy), 64'd0);
            last_c[s64] = val;
            if (cacheable) begin
                cvalid[s64] = 1; ca[s64] = ma; cb[s64] = mb; cw[s64] = ew;
            end
            @(posedge clk); #1;
            check({tag, ":pulse"}, 64'(done), 64'd0);
        end
    endtask

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = '1;
            2:       v = {$urandom, 32'h8000_0000};
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = 64'($urandom_range(0, 15));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic [63:0] pa, pb;
        rst = 1'b1; start = 1'b0; kill = 1'b0; word = 1'b0; sel64 = 1'b0;
        f3 = 3'b000; rs1 = '0; rs2 = '0;
        for (int i = 0; i < 2; i++) begin
            cvalid[i] = 0; last_c[i] = '0; ca[i] = '0; cb[i] = '0; cw[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst:c32", 64'(c32), 64'd0);
        check("rst:c64", c64, 64'd0);
        check("rst:done", 64'({done32, done64}), 64'd0);
        check("rst:busy", 64'({busy32, busy64}), 64'd0);

        run_op("mulh",      0, 3'b001, 0, 64'hFFFF_FFFF, 64'd2, 0, 0, 0);
        run_op("mul",       0, 3'b000, 0, 64'hFFFF_FFFF, 64'd2, 0, 0, 0);
        run_op("mulhu",     0, 3'b011, 0, 64'hFFFF_FFFF, 64'd2, 0, 0, 0);
        run_op("div_ovf",   0, 3'b100, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0);
        run_op("rem_ovf",   0, 3'b110, 0, 64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 0);
        run_op("divu_z",    0, 3'b101, 0, 64'd5, 64'd0, 0, 0, 0);
        run_op("remu_z",    0, 3'b111, 0, 64'd7, 64'd0, 0, 0, 0);
        run_op("div_m7",    0, 3'b100, 0, 64'hFFFF_FFF9, 64'd2, 0, 0, 0);
        run_op("rem_hit",   0, 3'b110, 0, 64'hFFFF_FFF9, 64'd2, 0, 0, 0);
        run_op("remu_hit",  0, 3'b111, 0, 64'd7, 64'd2, 0, 0, 0);
        run_op("divu_kill", 0, 3'b101, 0, 64'd100, 64'd7, 5, 0, 0);
        run_op("remu_poke", 0, 3'b111, 0, 64'd100, 64'd7, 0, 0, 10);
        run_op("divw",      1, 3'b100, 1, 64'h1234_5678_FFFF_FFF9, 64'd2, 0, 0, 0);
        run_op("mulw",      1, 3'b000, 1, 64'h7FFF_FFFF, 64'd2, 0, 0, 0);
        run_op("mulhu64",   1, 3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        run_op("div_rst",   0, 3'b100, 0, 64'd1000, 64'd3, 12, 1, 0);
        run_op("rem_full",  0, 3'b110, 0, 64'd1000, 64'd3, 0, 0, 0);

        pa = '0; pb = 64'd1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] rf;
            bit rs, rw;
            rs = 1'($urandom_range(0, 1));
            rf = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            if (i % 4 != 3) begin
                pa = pick(); pb = pick();
            end
            run_op("rand", rs, rf, rw, pa, pb, (i % 7 == 5) ? 1 : 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised successor to the single-cycle-multiply / restoring-divide M-extension unit.
- Implements all eight funct3 M ops at XLEN 32 or 64. For XLEN=64 it also implements the RV64M word ops (MULW/DIVW/DIVUW/REMW/REMUW).
- Multiplier is iterative, radix 2^MUL_STEP. Divider is radix-2 restoring, 1 bit per cycle.
- Adds a done pulse, a kill (flush) input, and a cached quotient/remainder pair. Sits in EX; the core stalls on busy_o.

Parameters:
XLEN, 32, operand/result width; legal values are 32 and 64.
MUL_STEP, 4, multiplier bits retired per cycle; must divide 32.
REM_CACHE, 1, 1 = keep last division's q/r for single-step reuse; 0 = no cache.

Ports:
clk  in  1  clock, rising edge.
rstHigh  in  1  synchronous reset, active-high.
start_i  in  1  request; accepted only when busy_o=0.
funct3_i  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
word_i  in  1  RV64 *W op. Ignored when XLEN=32. Ignored with funct3 001/010/011.
rs1_i  in  XLEN  multiplicand/dividend; sampled only at acceptance.
rs2_i  in  XLEN  multiplier/divisor; sampled only at acceptance.
kill_i  in  1  abort the in-flight op.
c_o  out  XLEN  result; registered, valid when done_o=1, held until next acceptance.
busy_o  out  1  high from the acceptance cycle (combinational on start_i) until the cycle before done_o.
done_o  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: rstHigh=1 forces state IDLE, c_o=0, done_o=0, busy_o=0 and cache invalid on the next edge, overriding everything including a mid-op. Inputs in the reset cycle are ignored.
- FSM states: IDLE, CALC, FIX.
- IDLE → FIX when start_i=1 and the op is special, a cache hit, or a word-mode div with the special case applied. IDLE → CALC when start_i=1 otherwise.
- Iteration counts: CALC runs K cycles. MUL: K = W/MUL_STEP. DIV: K = W. W = 32 if word mode, else XLEN.
- CALC → FIX after K cycles. FIX → IDLE, registering c_o and asserting done_o in the following cycle.
- Latency (acceptance cycle = 0; done_o asserted in cycle N):
  - MUL class: N = K+2.
  - DIV class: N = W+2.
  - Special case or cache hit: N = 2.
- Back-to-back: a new start_i is accepted in the done_o cycle.
- Start while busy: ignored; no effect on the in-flight op.
- Operand capture: signed ops (MUL, MULH, DIV, REM; rs1 of MULHSU) convert to magnitude at capture. Core operates on unsigned magnitudes.
- Word mode: operands taken from [31:0], sign- or zero-extended per op before the magnitude step. Result bit 31 is sign-extended into [63:32].
- FIX sign correction (two's complement):
  - MUL/MULH: negate the 2W product if the operand signs differ.
  - MULHSU: negate if rs1 is negative.
  - DIV: negate the quotient if the signs differ.
  - REM: negate the remainder if the dividend is negative.
  - MUL/MULW output the low W bits; MULH* output the high W bits.
- Special cases (no CALC):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = min negative, divisor = -1): quotient = dividend; remainder = 0.
- Remainder/quotient cache (REM_CACHE=1):
  - On DIV-class CALC completion, store the unsigned magnitudes a and b, word_i, and the unsigned q and r; set valid.
  - A DIV-class start with equal magnitudes and equal word_i is a hit: output comes from the cached q/r with the current op's sign fix.
  - Special cases do not update the cache. kill_i and reset invalidate it.
- kill_i:
  - In CALC/FIX: return to IDLE next edge with no done_o; c_o holds its previous value.
  - In the acceptance cycle: kill wins; the op is discarded.
  - In IDLE: no effect.
- Arithmetic width: the multiplier accumulator is 2W+MUL_STEP wide with no truncation before FIX. The divider partial remainder is W+1 bits.

Test Plan:
- XLEN=32, MUL_STEP=4: MULH 0xFFFFFFFF×0x00000002 → c_o=0xFFFFFFFF, done_o at cycle 10. MUL same operands → 0xFFFFFFFE. MULHU same → 0x00000001.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000, done cycle 2. REM same → 0. DIVU 5/0 → 0xFFFFFFFF. REMU 7/0 → 7. All take 2 cycles; cache stays invalid.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD, done cycle 34. Then REM same → 0xFFFFFFFF at cycle 2 (hit). Then REMU 7/2 → 1 at cycle 2 (hit on magnitudes).
- DIVU 100/7 with kill_i in cycle 5 → no done_o, busy_o=0 at cycle 6. Then REMU 100/7 → 2 at cycle 34 (cache invalid). start_i pulsed in cycle 10 of that op → ignored.
- XLEN=64: DIVW rs1=0x12345678_FFFFFFF9, rs2=2 → 0xFFFFFFFF_FFFFFFFD at cycle 34. MULW 0x7FFFFFFF×2 → 0xFFFFFFFF_FFFFFFFE at cycle 10. MULHU 0xFFFFFFFF_FFFFFFFF squared → 0xFFFFFFFF_FFFFFFFE at cycle 18.
- rstHigh asserted in cycle 12 of a DIV → next cycle c_o=0, busy_o=0, done_o=0. A subsequent same-operand REM takes the full 34 cycles.
